// File: rtl/ram_pkg.sv
// Shared constants and types for the RAM burst controller.
//   RAM_ADDR_WIDTH / RAM_DATA_WIDTH / RAM_LEN_WIDTH : default bus widths
//   RSP_DEPTH / RSP_PTR_WIDTH / RSP_CNT_WIDTH       : response buffer geometry
//   state_e                                         : controller states
package ram_pkg;

  localparam int unsigned RAM_ADDR_WIDTH = 8;
  localparam int unsigned RAM_DATA_WIDTH = 16;
  localparam int unsigned RAM_LEN_WIDTH  = 4;

  localparam int unsigned RSP_DEPTH      = 4;
  localparam int unsigned RSP_PTR_WIDTH  = 2;
  localparam int unsigned RSP_CNT_WIDTH  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/ram_rsp_fifo.sv
// Four-entry read-response buffer holding {tag, data} per beat.
//   clk, rst_n          : clock, async active-low reset (flushes the buffer)
//   push, push_data/tag : enqueue one beat (ignored when full)
//   pop                 : dequeue head beat (ignored when empty)
//   head_data/head_tag  : current head entry
//   empty, count        : occupancy
module ram_rsp_fifo
  import ram_pkg::*;
#(
  parameter int unsigned WIDTH = RAM_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     push_tag,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     head_tag,
  output logic                     empty,
  output logic [RSP_CNT_WIDTH-1:0] count
);

  logic [WIDTH-1:0]         data_mem [RSP_DEPTH];
  logic [RSP_DEPTH-1:0]     tag_mem;
  logic [RSP_PTR_WIDTH-1:0] wr_ptr;
  logic [RSP_PTR_WIDTH-1:0] rd_ptr;
  logic [RSP_CNT_WIDTH-1:0] cnt;
  logic                     do_push;
  logic                     do_pop;

  assign do_push   = push && (cnt != RSP_CNT_WIDTH'(RSP_DEPTH));
  assign do_pop    = pop && (cnt != '0);
  assign head_data = data_mem[rd_ptr];
  assign head_tag  = tag_mem[rd_ptr];
  assign empty     = (cnt == '0);
  assign count     = cnt;

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(RSP_DEPTH); i++) begin
        data_mem[i] <= '0;
      end
      tag_mem <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
    end else begin
      if (do_push) begin
        data_mem[wr_ptr] <= push_data;
        tag_mem[wr_ptr]  <= push_tag;
        wr_ptr           <= wr_ptr + RSP_PTR_WIDTH'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + RSP_PTR_WIDTH'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + RSP_CNT_WIDTH'(1);
        2'b01:   cnt <= cnt - RSP_CNT_WIDTH'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst controller in front of a single-port synchronous RAM.
//   cmd_*  : host burst command (valid/ready), accepted only in IDLE
//   wr_*   : write beats (valid/ready), accepted only in WRITE
//   rd_*   : read beats from the response buffer (valid/ready), rd_last on final beat
//   busy   : controller not idle
//   ram_*  : RAM port; ram_dout is valid one cycle after ram_addr is presented
// Read addresses are launched from a register, so a beat is pushed into the
// buffer two edges after its issue; up to two beats can be in flight.
module ram_burst_ctrl
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = RAM_DATA_WIDTH,
  parameter int unsigned LEN_WIDTH  = RAM_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  busy,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam int unsigned BEAT_WIDTH = LEN_WIDTH + 1;
  localparam int unsigned CRED_WIDTH = RSP_CNT_WIDTH + 1;

  state_e                   state;
  state_e                   state_nxt;
  logic [ADDR_WIDTH-1:0]    cur_addr;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [BEAT_WIDTH-1:0]    beats_left;
  logic                     s1_vld;
  logic                     s1_last;
  logic                     s2_vld;
  logic                     s2_last;
  logic                     cmd_fire_c;
  logic                     wr_fire_c;
  logic                     issue_c;
  logic                     last_beat_c;
  logic                     credit_ok_c;
  logic                     fifo_empty;
  logic                     fifo_tag;
  logic [RSP_CNT_WIDTH-1:0] fifo_count;
  logic                     rd_pop_c;

  assign last_beat_c = (beats_left == BEAT_WIDTH'(1));
  // Buffered plus in-flight beats must never exceed the buffer depth
  assign credit_ok_c = (CRED_WIDTH'(fifo_count) + CRED_WIDTH'(s1_vld) + CRED_WIDTH'(s2_vld))
                       < CRED_WIDTH'(RSP_DEPTH);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and port control
  always_comb begin
    state_nxt  = state;
    cmd_fire_c = 1'b0;
    wr_fire_c  = 1'b0;
    issue_c    = 1'b0;
    cmd_ready  = 1'b0;
    wr_ready   = 1'b0;
    busy       = 1'b1;
    ram_we     = 1'b0;
    ram_addr   = addr_q;
    ram_din    = '0;
    case (state)
      ST_IDLE: begin
        cmd_ready  = 1'b1;
        busy       = 1'b0;
        cmd_fire_c = cmd_valid;
        if (cmd_valid) begin
          state_nxt = cmd_write ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        wr_ready  = 1'b1;
        ram_we    = wr_valid;
        ram_addr  = cur_addr;
        ram_din   = wr_data;
        wr_fire_c = wr_valid;
        if (wr_valid && last_beat_c) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_READ: begin
        issue_c = credit_ok_c;
        if (credit_ok_c && last_beat_c) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!s1_vld && !s2_vld && fifo_empty) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Address/beat counters and the read-issue pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr   <= '0;
      addr_q     <= '0;
      beats_left <= '0;
      s1_vld     <= 1'b0;
      s1_last    <= 1'b0;
      s2_vld     <= 1'b0;
      s2_last    <= 1'b0;
    end else begin
      if (cmd_fire_c) begin
        cur_addr   <= cmd_addr;
        beats_left <= BEAT_WIDTH'(cmd_len) + BEAT_WIDTH'(1);
      end else if (wr_fire_c || issue_c) begin
        cur_addr   <= cur_addr + ADDR_WIDTH'(1);
        beats_left <= beats_left - BEAT_WIDTH'(1);
        addr_q     <= cur_addr;
      end
      s1_vld  <= issue_c;
      s1_last <= issue_c && last_beat_c;
      s2_vld  <= s1_vld;
      s2_last <= s1_last;
    end
  end

  assign rd_pop_c = rd_ready && !fifo_empty;

  ram_rsp_fifo #(
    .WIDTH(DATA_WIDTH)
  ) u_rsp_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (s2_vld),
    .push_data(ram_dout),
    .push_tag (s2_last),
    .pop      (rd_pop_c),
    .head_data(rd_data),
    .head_tag (fifo_tag),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign rd_valid = !fifo_empty;
  assign rd_last  = !fifo_empty && fifo_tag;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Self-checking bench for ram_burst_ctrl: a bench-side RAM model, a reference
// memory image updated from the beats the bench sends, a table of directed
// bursts, hand-written corner sequences and randomized write/read-back pairs.
`timescale 1ns/1ps
module tb_ram_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr;
  logic [3:0]  cmd_len;
  logic        wr_valid, wr_ready;
  logic [15:0] wr_data;
  logic        rd_valid, rd_ready, rd_last, busy;
  logic [15:0] rd_data;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [15:0] ram_din, ram_dout;

  always #5 clk = ~clk;

  ram_burst_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .busy(busy),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Single-port RAM: write on we, otherwise registered read
  logic [15:0] ram_mem [256];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    else        ram_dout <= ram_mem[ram_addr];
  end

  // Reference image: what the RAM must hold, from the host's point of view
  logic [15:0] ref_mem [256];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Every RAM write must match the next beat the host sent, in order
  typedef struct packed { logic [7:0] addr; logic [15:0] data; } wr_t;
  wr_t exp_wq[$];
  int  n_ram_writes = 0;

  always @(negedge clk) begin
    wr_t e;
    if (rst_n === 1'b1 && ram_we === 1'b1) begin
      n_ram_writes++;
      if (exp_wq.size() == 0) begin
        check("write_unexpected", 32'(ram_we), 32'h0);
      end else begin
        e = exp_wq.pop_front();
        check("write_addr_data", {8'h0, ram_addr, ram_din}, {8'h0, e.addr, e.data});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic wr, input logic [7:0] a, input logic [3:0] l);
    logic hs;
    int   t;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l;
    hs = 1'b0; t = 0;
    while (!hs && t < 50) begin
      hs = cmd_ready;
      step();
      t++;
    end
    cmd_valid = 1'b0;
    if (!hs) check("cmd_handshake_timeout", 32'(cmd_ready), 32'h1);
  endtask

  task automatic write_burst(input logic [7:0] a, input logic [3:0] l, input logic [15:0] base,
                             input bit rand_gap, input bit rand_data);
    logic [15:0] d;
    logic [7:0]  wa;
    send_cmd(1'b1, a, l);
    for (int i = 0; i <= int'(l); i++) begin
      if (rand_gap && $urandom_range(0, 2) == 0) begin
        wr_valid = 1'b0;
        step();
      end
      d  = rand_data ? 16'($urandom) : base + 16'(i);
      wa = a + 8'(i);
      exp_wq.push_back({wa, d});
      ref_mem[wa] = d;
      wr_valid = 1'b1; wr_data = d;
      step();
    end
    wr_valid = 1'b0; wr_data = 16'h0;
    check("write_queue_drained", 32'(exp_wq.size()), 32'h0);
  endtask

  task automatic read_burst(input logic [7:0] a, input logic [3:0] l, input int hold_low,
                            input bit rand_ready, input bit chk_lat,
                            output logic [15:0] first_d, output logic [15:0] last_d);
    int         beats, got, t, first_t, gaps;
    logic [7:0] ra;
    beats = int'(l) + 1; got = 0; t = 0; first_t = -1; gaps = 0;
    first_d = 16'hx; last_d = 16'hx;
    rd_ready = (hold_low == 0) && !rand_ready;
    send_cmd(1'b0, a, l);
    while (got < beats && t < 400) begin
      if (t < hold_low)    rd_ready = 1'b0;
      else if (rand_ready) rd_ready = ($urandom_range(0, 3) != 0);
      else                 rd_ready = 1'b1;
      if (t < hold_low && rd_valid) begin
        check("rd_data_held", 32'(rd_data), 32'(ref_mem[a]));
      end
      if (hold_low >= 8 && l >= 4'd3 && t == hold_low - 1) begin
        check("bp_rd_valid", 32'(rd_valid), 32'h1);
        check("bp_issue_stop_addr", 32'(ram_addr), 32'(a + 8'd3));
        check("bp_busy", 32'(busy), 32'h1);
      end
      if (rd_valid) begin
        if (first_t < 0) first_t = t;
        if (rd_ready) begin
          ra = a + 8'(got);
          check("rd_data", 32'(rd_data), 32'(ref_mem[ra]));
          check("rd_last", 32'(rd_last), 32'(got == beats - 1));
          if (got == 0) first_d = rd_data;
          if (got == beats - 1) last_d = rd_data;
          got++;
        end
      end else if (first_t >= 0 && !rand_ready) begin
        gaps++;
      end
      step();
      t++;
    end
    rd_ready = 1'b0;
    if (got < beats) check("read_beats_timeout", 32'(got), 32'(beats));
    if (chk_lat) check("first_rd_valid_latency", 32'(first_t), 32'd3);
    if (!rand_ready) check("read_bubbles", 32'(gaps), 32'h0);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!cmd_ready && t < 20) begin
      step();
      t++;
    end
    check("return_to_idle", 32'(cmd_ready), 32'h1);
  endtask

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [3:0]  len;
    logic [15:0] base;
    int          exp_beats;
    logic [7:0]  exp_end;
    logic [15:0] exp_first;
    logic [15:0] exp_last;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] fd, ld;
    int          wbase;

    vecs[0] = '{1'b1, 8'h10, 4'd3,  16'hA000, 4,  8'h13, 16'hA000, 16'hA003};
    vecs[1] = '{1'b0, 8'h10, 4'd3,  16'h0000, 4,  8'h13, 16'hA000, 16'hA003};
    vecs[2] = '{1'b1, 8'hFE, 4'd2,  16'hB000, 3,  8'h00, 16'hB000, 16'hB002};
    vecs[3] = '{1'b0, 8'hFE, 4'd2,  16'h0000, 3,  8'h00, 16'hB000, 16'hB002};
    vecs[4] = '{1'b1, 8'h40, 4'd0,  16'hC000, 1,  8'h40, 16'hC000, 16'hC000};
    vecs[5] = '{1'b0, 8'h40, 4'd0,  16'h0000, 1,  8'h40, 16'hC000, 16'hC000};
    vecs[6] = '{1'b1, 8'h80, 4'd15, 16'hD000, 16, 8'h8F, 16'hD000, 16'hD00F};
    vecs[7] = '{1'b0, 8'h80, 4'd15, 16'h0000, 16, 8'h8F, 16'hD000, 16'hD00F};

    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h0; cmd_len = 4'h0;
    wr_valid = 1'b0; wr_data = 16'h0; rd_ready = 1'b0;
    repeat (3) step();

    // Reset values
    check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    check("rst_wr_ready",  32'(wr_ready),  32'h0);
    check("rst_rd_valid",  32'(rd_valid),  32'h0);
    check("rst_rd_last",   32'(rd_last),   32'h0);
    check("rst_rd_data",   32'(rd_data),   32'h0);
    check("rst_busy",      32'(busy),      32'h0);
    check("rst_ram_port",  {7'h0, ram_we, ram_addr, ram_din}, 32'h0);
    rst_n = 1'b1;
    step();

    // Directed burst table
    for (int v = 0; v < 8; v++) begin
      wbase = n_ram_writes;
      if (vecs[v].wr) begin
        write_burst(vecs[v].addr, vecs[v].len, vecs[v].base, 1'b0, 1'b0);
        check("w_write_count", 32'(n_ram_writes - wbase), 32'(vecs[v].exp_beats));
        check("w_cmd_ready_after", 32'(cmd_ready), 32'h1);
      end else begin
        read_burst(vecs[v].addr, vecs[v].len, 0, 1'b0, 1'b1, fd, ld);
        check("r_first_data", 32'(fd), 32'(vecs[v].exp_first));
        check("r_last_data",  32'(ld), 32'(vecs[v].exp_last));
        check("r_no_writes",  32'(n_ram_writes - wbase), 32'h0);
        wait_idle();
      end
      check("end_ram_addr", 32'(ram_addr), 32'(vecs[v].exp_end));
    end

    // Long read with the host stalled for 10 cycles
    read_burst(8'h80, 4'd15, 10, 1'b0, 1'b0, fd, ld);
    check("bp_first_data", 32'(fd), 32'hD000);
    check("bp_last_data",  32'(ld), 32'hD00F);
    wait_idle();

    // Gapped write beats, a stray command while busy, and wr_valid in IDLE
    wbase = n_ram_writes;
    send_cmd(1'b1, 8'h50, 4'd1);
    exp_wq.push_back({8'h50, 16'h5A00}); ref_mem[8'h50] = 16'h5A00;
    wr_valid = 1'b1; wr_data = 16'h5A00;
    step();
    wr_valid = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h99; cmd_len = 4'hF;
    check("cmd_ready_while_busy", 32'(cmd_ready), 32'h0);
    check("busy_mid_write", 32'(busy), 32'h1);
    step();
    cmd_valid = 1'b0;
    exp_wq.push_back({8'h51, 16'h5A01}); ref_mem[8'h51] = 16'h5A01;
    wr_valid = 1'b1; wr_data = 16'h5A01;
    step();
    wr_data = 16'hDEAD;
    check("wr_ready_in_idle", 32'(wr_ready), 32'h0);
    step();
    wr_valid = 1'b0;
    step();
    check("gapped_write_count", 32'(n_ram_writes - wbase), 32'd2);
    check("stray_cmd_ignored", {30'h0, busy, cmd_ready}, 32'h1);
    read_burst(8'h50, 4'd1, 0, 1'b0, 1'b1, fd, ld);
    check("gapped_readback", {ld, fd}, 32'h5A01_5A00);
    wait_idle();

    // Reset in the middle of a read burst
    send_cmd(1'b0, 8'h80, 4'd15);
    rd_ready = 1'b1;
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    check("midrst_rd_valid",  32'(rd_valid),  32'h0);
    check("midrst_busy",      32'(busy),      32'h0);
    check("midrst_cmd_ready", 32'(cmd_ready), 32'h1);
    check("midrst_ram_we",    32'(ram_we),    32'h0);
    rd_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    check("postrst_ram_addr", 32'(ram_addr), 32'h0);
    read_burst(8'h10, 4'd3, 0, 1'b0, 1'b1, fd, ld);
    check("postrst_first", 32'(fd), 32'hA000);
    check("postrst_last",  32'(ld), 32'hA003);
    wait_idle();

    // Randomized write bursts followed by read-back of a sub-range
    for (int it = 0; it < 20; it++) begin
      logic [7:0] wa, ra;
      logic [3:0] wl, rl;
      int         off;
      wa = 8'($urandom);
      wl = 4'($urandom);
      write_burst(wa, wl, 16'h0, 1'b1, 1'b1);
      off = $urandom_range(0, int'(wl));
      ra  = wa + 8'(off);
      rl  = 4'($urandom_range(0, int'(wl) - off));
      read_burst(ra, rl, 0, 1'b1, 1'b0, fd, ld);
      wait_idle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ram_burst_ctrl.md
Name: ram_burst_ctrl

Overview:
Burst request controller directly upstream of the single-port synchronous RAM (write on we=1, registered read data one cycle after address with we=0). Accepts read/write burst commands from a host over valid/ready, generates the RAM's we/addr/din with auto-incrementing addresses, and returns read data through a 4-entry response buffer with backpressure. Owns all RAM port timing so host logic never sees RAM read latency.

Parameters:
ADDR_WIDTH, 8, RAM address width; burst address wraps modulo 2^ADDR_WIDTH
DATA_WIDTH, 16, RAM data width
LEN_WIDTH, 4, burst length field width; beats = cmd_len+1 (1..16)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  controller accepts command (high only in IDLE)
cmd_write  in  1  1=write burst, 0=read burst
cmd_addr  in  ADDR_WIDTH  start address
cmd_len  in  LEN_WIDTH  beats minus one
wr_valid  in  1  write beat offered
wr_ready  out  1  write beat accepted (high only in WRITE)
wr_data  in  DATA_WIDTH  write beat data
rd_valid  out  1  read beat available (buffer non-empty)
rd_ready  in  1  host consumes read beat
rd_data  out  DATA_WIDTH  read beat data (buffer head)
rd_last  out  1  head beat is final beat of burst
busy  out  1  state != IDLE
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_WIDTH  RAM address
ram_din  out  DATA_WIDTH  RAM write data
ram_dout  in  DATA_WIDTH  RAM read data

Behaviour:
- Reset (async assert, sync release): state IDLE, buffer empty, in-flight flag 0, address/beat counters 0. Outputs: cmd_ready=1, wr_ready=0, rd_valid=0, rd_last=0, rd_data=0, busy=0, ram_we=0, ram_addr=0, ram_din=0.
- States: IDLE, WRITE, READ, DRAIN.
- IDLE: cmd handshake latches addr, beats=cmd_len+1, next state WRITE or READ per cmd_write.
- WRITE: wr_ready=1; ram_we=wr_valid (combinational), ram_addr=cur_addr, ram_din=wr_data. Each handshake writes RAM at that edge, increments addr (wrap FF->00 for ADDR_WIDTH=8), decrements remaining; last beat -> IDLE. wr_valid low = stall, no write.
- READ: issue when buffer count + in-flight < 4: ram_we=0, ram_addr=cur_addr, set in-flight with last tag. Cycle after issue, ram_dout captured into buffer with tag. After last issue -> DRAIN. With rd_ready held high: first rd_valid 3 cycles after cmd handshake edge, then one beat/cycle, no bubbles.
- DRAIN: no issues; -> IDLE when in-flight=0 and last-tagged beat popped (buffer empty).
- ram_we=0 in all states except WRITE with wr_valid. ram_addr holds last value when not issuing.
- Buffer: 4 entries x (DATA_WIDTH+1); simultaneous push and pop when full is impossible by credit rule; push+pop same cycle keeps count. Never overflows; rd_valid/rd_data stable while rd_ready=0.
- cmd_valid outside IDLE ignored; wr_valid outside WRITE ignored; rd_ready with rd_valid=0 no effect.
- Reset mid-burst: abort immediately; buffer flushed; already-written RAM words remain.

Decomposition:
- Package ram_pkg: default ADDR_WIDTH/DATA_WIDTH/LEN_WIDTH constants, state enum (IDLE, WRITE, READ, DRAIN), RSP_DEPTH=4.
- Sub-module ram_rsp_fifo: 4-deep synchronous FIFO with count, push/pop, tag bit, same reset.

Test Plan:
- Write burst addr=0x10 len=3 data 0xA000..0xA003, wr_valid continuous -> ram_we high 4 cycles, addresses 0x10..0x13, then cmd_ready=1.
- Read burst addr=0x10 len=3, rd_ready=1 -> rd_valid 3 cycles after cmd edge, data 0xA000..0xA003 on consecutive cycles, rd_last only on 0xA003.
- Read len=15 with rd_ready low 10 cycles -> exactly 4 beats buffered, no further issues, no data loss; release -> all 16 beats in order.
- Write addr=0xFE len=2 then read back -> addresses 0xFE,0xFF,0x00 written and returned correctly.
- wr_valid toggled 1,0,1,0 during len=1 write -> only 2 RAM writes; cmd_valid pulsed while busy -> ignored.
- rst_n asserted mid read burst -> rd_valid=0, busy=0, cmd_ready=1 immediately; new read after release returns correct data.
